qpsk_symbol_demod: RTL and testbench

- Receive-side counterpart of the 4-way carrier-select modulator.
- Takes the serial 1-bit modulated stream and the same four reference carrier waveforms the modulator selects between.
- Correlates the stream against each reference over one symbol period and recovers the 2-bit symbol.
- Presents recovered symbols on a valid/ready output with a one-entry holding register, ahead of the framing logic.

---
 rtl/qpsk_symbol_demod.sv | 193 +++++++++++++++++++
 tb/tb_qpsk_symbol_demod.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qpsk_symbol_demod.sv
// qpsk_symbol_demod
//   Receive side of the 4-way carrier-select modulator. The serial 1-bit
//   stream is correlated against the four reference carriers over one symbol
//   of SYM_LEN valid samples. The reference with the most matching samples
//   gives the recovered 2-bit symbol (ties go to the lowest index). The
//   symbol is presented on a valid/ready output with a one-entry holding
//   register.
//
//   Optional feature macro: DEMOD_THRESH_EN
//     defined   : sym_err flags a winning count below MIN_MATCH.
//     undefined : sym_err is tied 0 and no comparator is built.
//
// Parameters
//   SYM_LEN    samples per symbol (>= 2)
//   MIN_MATCH  minimum winning count (threshold build only)
//   CW         width of the correlation counts, $clog2(SYM_LEN+1)
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   sym_start     in   symbol boundary strobe: clears counters, (re)starts
//   sample_valid  in   rx_bit / ref0..ref3 valid this cycle
//   rx_bit        in   received modulated sample
//   ref0..ref3    in   reference carriers for symbols 0..3
//   sym_out       out  recovered symbol
//   sym_conf      out  winning match count, 0..SYM_LEN
//   sym_valid     out  output register holds an unaccepted symbol
//   sym_ready     in   downstream accepts
//   overrun       out  sticky: a decided symbol was dropped
//   sym_err       out  winning count below MIN_MATCH (threshold build only)
module qpsk_symbol_demod #(
   parameter int  SYM_LEN   = 16,
   parameter int  MIN_MATCH = 12,
   localparam int CW        = $clog2(SYM_LEN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sym_start,
   input  logic          sample_valid,
   input  logic          rx_bit,
   input  logic          ref0,
   input  logic          ref1,
   input  logic          ref2,
   input  logic          ref3,
   output logic [1:0]    sym_out,
   output logic [CW-1:0] sym_conf,
   output logic          sym_valid,
   input  logic          sym_ready,
   output logic          overrun,
   output logic          sym_err
);

   if (SYM_LEN < 2 || MIN_MATCH < 0 || MIN_MATCH > SYM_LEN) begin : g_param_check
      $error("qpsk_symbol_demod: need SYM_LEN >= 2 and 0 <= MIN_MATCH <= SYM_LEN");
   end

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ACCUM = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          accum_en;
   logic [3:0]    match_p0;
   logic          last_p0;
   logic [CW-1:0] scnt;
   logic [CW-1:0] acc [4];
   logic [CW-1:0] snap_p1 [4];
   logic          vld_p1;
   logic [1:0]    win_sym;
   logic [CW-1:0] win_conf;
   logic [1:0]    dec_sym_p2;
   logic [CW-1:0] dec_conf_p2;
   logic          vld_p2;
   logic          load;
   logic          drop;

   // Argmax over four counts; strict '>' keeps the lowest index on a tie.
   function automatic logic [1:0] argmax4(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                                          input logic [CW-1:0] c2, input logic [CW-1:0] c3);
      logic [1:0]    idx;
      logic [CW-1:0] best;
      idx  = 2'd0;
      best = c0;
      if (c1 > best) begin idx = 2'd1; best = c1; end
      if (c2 > best) begin idx = 2'd2; best = c2; end
      if (c3 > best) begin idx = 2'd3; end
      return idx;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (sym_start) state_nxt = S_ACCUM;
         S_ACCUM: state_nxt = S_ACCUM;
         default: state_nxt = S_IDLE;
      endcase
   end

   // A sample arriving together with sym_start belongs to no symbol.
   always_comb begin
      accum_en = (state == S_ACCUM) && sample_valid && !sym_start;
   end

   // ---- stage p0: per-sample match and accumulation ----
   assign match_p0 = ~({ref3, ref2, ref1, ref0} ^ {4{rx_bit}});
   assign last_p0  = accum_en && (scnt == CW'(SYM_LEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scnt <= '0;
         for (int k = 0; k < 4; k++) acc[k] <= '0;
      end else if (sym_start || last_p0) begin
         scnt <= '0;
         for (int k = 0; k < 4; k++) acc[k] <= '0;
      end else if (accum_en) begin
         scnt <= scnt + CW'(1);
         for (int k = 0; k < 4; k++) acc[k] <= acc[k] + CW'(match_p0[k]);
      end
   end

   // ---- stage p1: snapshot of the final counts, freeing acc for the next symbol ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         for (int k = 0; k < 4; k++) snap_p1[k] <= '0;
      end else begin
         vld_p1 <= last_p0;
         if (last_p0) begin
            for (int k = 0; k < 4; k++) snap_p1[k] <= acc[k] + CW'(match_p0[k]);
         end
      end
   end

   assign win_sym  = argmax4(snap_p1[0], snap_p1[1], snap_p1[2], snap_p1[3]);
   assign win_conf = snap_p1[win_sym];

   // ---- stage p2: registered decision offered to the output register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p2      <= 1'b0;
         dec_sym_p2  <= '0;
         dec_conf_p2 <= '0;
      end else begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            dec_sym_p2  <= win_sym;
            dec_conf_p2 <= win_conf;
         end
      end
   end

   // ---- output holding register ----
   // A full register accepted this cycle may reload in the same cycle.
   assign load = vld_p2 && (!sym_valid || sym_ready);
   assign drop = vld_p2 && sym_valid && !sym_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_out   <= '0;
         sym_conf  <= '0;
         sym_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            sym_out   <= dec_sym_p2;
            sym_conf  <= dec_conf_p2;
            sym_valid <= 1'b1;
         end else if (sym_valid && sym_ready) begin
            sym_valid <= 1'b0;
         end
         // A drop on the same edge as sym_start is still reported.
         if (drop)           overrun <= 1'b1;
         else if (sym_start) overrun <= 1'b0;
      end
   end

`ifdef DEMOD_THRESH_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    sym_err <= 1'b0;
      else if (load) sym_err <= (dec_conf_p2 < CW'(MIN_MATCH));
   end
`else
   assign sym_err = 1'b0;
`endif

endmodule

// File: tb/tb_qpsk_symbol_demod.sv
// Self-checking bench for qpsk_symbol_demod: directed symbols with
// hand-computed results plus a symbol-level reference model compared
// against the DUT outputs on every cycle.
module tb_qpsk_symbol_demod;
   localparam int SYM_LEN   = 16;
   localparam int MIN_MATCH = 12;
   localparam int CW        = $clog2(SYM_LEN + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          sym_start = 1'b0;
   logic          sample_valid = 1'b0;
   logic          rx_bit = 1'b0;
   logic          ref0 = 1'b0, ref1 = 1'b0, ref2 = 1'b0, ref3 = 1'b0;
   logic          sym_ready = 1'b0;
   logic [1:0]    sym_out;
   logic [CW-1:0] sym_conf;
   logic          sym_valid, overrun, sym_err;

   always #5 clk = ~clk;

   qpsk_symbol_demod #(.SYM_LEN(SYM_LEN), .MIN_MATCH(MIN_MATCH)) u_dut (
      .clk(clk), .rst_n(rst_n), .sym_start(sym_start), .sample_valid(sample_valid),
      .rx_bit(rx_bit), .ref0(ref0), .ref1(ref1), .ref2(ref2), .ref3(ref3),
      .sym_out(sym_out), .sym_conf(sym_conf), .sym_valid(sym_valid),
      .sym_ready(sym_ready), .overrun(overrun), .sym_err(sym_err)
   );

   int checks = 0;
   int failures = 0;

   function automatic void check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endfunction

   function automatic int thresh_err(input int conf);
`ifdef DEMOD_THRESH_EN
      return (conf < MIN_MATCH) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   // ------------------------------------------------------------------
   // Reference model: collect a whole symbol's samples, then correlate.
   // ------------------------------------------------------------------
   typedef struct {
      int          due;
      logic [1:0]  s;
      int          c;
   } dec_t;

   dec_t       pend[$];
   logic [4:0] smp [SYM_LEN];    // {rx, ref3, ref2, ref1, ref0}
   int         nsmp = 0;
   int         ecyc = 0;
   bit         m_act = 0, m_valid = 0, m_ovr = 0;
   int         m_sym = 0, m_conf = 0, m_err = 0;

   function automatic void correlate(output logic [1:0] s, output int c);
      int cnt [4];
      for (int k = 0; k < 4; k++) begin
         cnt[k] = 0;
         for (int i = 0; i < SYM_LEN; i++)
            if (smp[i][4] == smp[i][k]) cnt[k]++;
      end
      s = 2'd0;
      c = cnt[0];
      for (int k = 1; k < 4; k++)
         if (cnt[k] > c) begin s = 2'(k); c = cnt[k]; end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      bit   arrive;
      dec_t d;
      logic [1:0] s;
      int   c;
      if (!rst_n) begin
         pend.delete();
         nsmp = 0; ecyc = 0; m_act = 0; m_valid = 0; m_ovr = 0;
         m_sym = 0; m_conf = 0; m_err = 0;
      end else begin
         ecyc++;
         arrive = 0;
         if (pend.size() > 0 && pend[0].due == ecyc) begin
            arrive = 1;
            d = pend.pop_front();
         end
         if (sym_start) m_ovr = 0;
         if (arrive) begin
            if (!m_valid || sym_ready) begin
               m_valid = 1; m_sym = d.s; m_conf = d.c; m_err = thresh_err(d.c);
            end else begin
               m_ovr = 1;
            end
         end else if (m_valid && sym_ready) begin
            m_valid = 0;
         end
         if (sym_start) begin
            m_act = 1;
            nsmp = 0;
         end else if (m_act && sample_valid) begin
            smp[nsmp] = {rx_bit, ref3, ref2, ref1, ref0};
            nsmp++;
            if (nsmp == SYM_LEN) begin
               correlate(s, c);
               pend.push_back('{due: ecyc + 2, s: s, c: c});
               nsmp = 0;
            end
         end
      end
   end

   // Per-cycle compare against the model, plus a log of accepted symbols.
   bit chk_en = 0;
   int ncyc = 0;
   int log_sym[$];
   int log_t[$];

   always @(negedge clk) begin
      ncyc++;
      if (chk_en) begin
         check("sym_valid", sym_valid, m_valid);
         check("sym_out", sym_out, m_sym);
         check("sym_conf", sym_conf, m_conf);
         check("sym_err", sym_err, m_err);
         check("overrun", overrun, m_ovr);
         if (sym_valid && sym_ready) begin
            log_sym.push_back(sym_out);
            log_t.push_back(ncyc);
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   logic [15:0] r0, r1, r2, r3;

   task automatic start_sym();
      @(negedge clk);
      sym_start = 1'b1;
      sample_valid = 1'b1;      // must be ignored
      rx_bit = 1'b1;
   endtask

   task automatic send(input logic [15:0] rx, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sym_start = 1'b0;
         sample_valid = 1'b1;
         rx_bit = rx[i];
         ref0 = r0[i]; ref1 = r1[i]; ref2 = r2[i]; ref3 = r3[i];
      end
   endtask

   task automatic idle(input int n);
      @(negedge clk);
      sym_start = 1'b0;
      sample_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Edges after the one that samples the last sample until sym_valid is seen.
   task automatic wait_valid(output int lat);
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      lat = 0;
      while (!sym_valid && lat < 10) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic accept();
      @(negedge clk);
      sym_ready = 1'b1;
      @(negedge clk);
      sym_ready = 1'b0;
   endtask

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog timeout");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int lat;
      int vcount;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_en = 1;
      check("reset_sym_out", sym_out, 0);
      check("reset_sym_conf", sym_conf, 0);
      check("reset_sym_valid", sym_valid, 0);
      check("reset_overrun", overrun, 0);
      check("reset_sym_err", sym_err, 0);
      #2 rst_n = 1'b1;

      // Clean symbol: rx = ref2. Matches: ref0 8, ref1 8, ref2 16, ref3 8.
      r0 = 16'h0000; r1 = 16'hFFFF; r2 = 16'h00FF; r3 = 16'h0F0F;
      start_sym();
      send(16'h00FF, SYM_LEN);
      wait_valid(lat);
      check("clean_latency", lat, 2);
      check("clean_sym", sym_out, 2);
      check("clean_conf", sym_conf, 16);
      accept();
      check("clean_accepted", sym_valid, 0);

      // Tie: ref1 == ref3 == rx, ref0/ref2 inverted -> lowest index 1.
      r0 = 16'hC3A5; r1 = 16'h3C5A; r2 = 16'hC3A5; r3 = 16'h3C5A;
      start_sym();
      send(16'h3C5A, SYM_LEN);
      wait_valid(lat);
      check("tie_sym", sym_out, 1);
      check("tie_conf", sym_conf, 16);
      accept();

      // Continuous stream 3, 0, 1 with sym_ready held high.
      r0 = 16'h0000; r1 = 16'hFFFF; r2 = 16'h00FF; r3 = 16'h0F0F;
      @(negedge clk);
      sym_ready = 1'b1;
      log_sym.delete();
      log_t.delete();
      start_sym();
      send(16'h0F0F, SYM_LEN);
      send(16'h0000, SYM_LEN);
      send(16'hFFFF, SYM_LEN);
      idle(6);
      check("stream_count", log_sym.size(), 3);
      if (log_sym.size() == 3) begin
         check("stream_sym0", log_sym[0], 3);
         check("stream_sym1", log_sym[1], 0);
         check("stream_sym2", log_sym[2], 1);
         check("stream_gap01", log_t[1] - log_t[0], 16);
         check("stream_gap12", log_t[2] - log_t[1], 16);
      end
      check("stream_overrun", overrun, 0);

      // Backpressure: second decision is dropped while the first is held.
      @(negedge clk);
      sym_ready = 1'b0;
      start_sym();
      send(16'h0000, SYM_LEN);
      send(16'hFFFF, SYM_LEN);
      idle(4);
      check("bp_held_valid", sym_valid, 1);
      check("bp_held_sym", sym_out, 0);
      check("bp_overrun", overrun, 1);
      @(negedge clk);
      sym_ready = 1'b1;
      @(negedge clk);
      check("bp_handshake", sym_valid, 0);
      check("bp_overrun_sticky", overrun, 1);
      sym_ready = 1'b0;
      start_sym();
      idle(0);
      check("bp_overrun_clear", overrun, 0);

      // Resync after 9 samples, then a full symbol of ref0.
      start_sym();
      send(16'hFFFF, 9);
      start_sym();
      send(16'h0000, SYM_LEN);
      wait_valid(lat);
      check("resync_latency", lat, 2);
      check("resync_sym", sym_out, 0);
      check("resync_conf", sym_conf, 16);

      // Asynchronous reset mid-symbol while a symbol is still held.
      start_sym();
      send(16'hFFFF, 7);
      @(negedge clk);
      #2 rst_n = 1'b0;
      sample_valid = 1'b0;
      #1;
      check("arst_valid", sym_valid, 0);
      check("arst_conf", sym_conf, 0);
      check("arst_overrun", overrun, 0);
      @(negedge clk);
      #2 rst_n = 1'b1;
      // No sym_start yet: samples must be ignored.
      send(16'h0000, SYM_LEN);
      sample_valid = 1'b0;
      vcount = 0;
      repeat (6) begin
         @(negedge clk);
         if (sym_valid) vcount++;
      end
      check("idle_no_valid", vcount, 0);
      start_sym();
      send(16'h0000, SYM_LEN);
      wait_valid(lat);
      check("post_reset_latency", lat, 2);
      check("post_reset_sym", sym_out, 0);
      accept();

      // Threshold: ref3 wins with 11 (ref0 9, ref1 7, ref2 5), then with 12.
      r0 = 16'h0000; r1 = 16'hFFFF; r2 = 16'hF0F0; r3 = 16'h0F0F;
      start_sym();
      send(16'h0F38, SYM_LEN);
      wait_valid(lat);
      check("thr11_sym", sym_out, 3);
      check("thr11_conf", sym_conf, 11);
`ifdef DEMOD_THRESH_EN
      check("thr11_err", sym_err, 1);
`else
      check("thr11_err", sym_err, 0);
`endif
      accept();
      start_sym();
      send(16'h0F3C, SYM_LEN);
      wait_valid(lat);
      check("thr12_sym", sym_out, 3);
      check("thr12_conf", sym_conf, 12);
      check("thr12_err", sym_err, 0);
      accept();
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
